// File: rtl/key_debounce_mc.sv
// Multi-channel key debouncer: 2-flop sync, per-direction stability filter,
// and registered one-cycle press / release / long-press pulses per channel.
module key_debounce_mc #(
    parameter int C_CLK_PRD_NS              = 10,
    parameter int C_CHANNELS                = 4,
    parameter int C_LOW_LEVEL_THRESHOLD_US  = 20,
    parameter int C_HIGH_LEVEL_THRESHOLD_US = 20,
    parameter bit C_KEY_ACTIVE              = 1'b1,
    parameter int C_LONG_PRESS_US           = 1000000
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic [C_CHANNELS-1:0] KEY_I,
    output logic [C_CHANNELS-1:0] KEY_O,
    output logic [C_CHANNELS-1:0] PRESS_O,
    output logic [C_CHANNELS-1:0] RELEASE_O,
    output logic [C_CHANNELS-1:0] LONG_O
);

    localparam longint N_LOW_RAW  = longint'(C_LOW_LEVEL_THRESHOLD_US) * 1000 / longint'(C_CLK_PRD_NS);
    localparam longint N_HIGH_RAW = longint'(C_HIGH_LEVEL_THRESHOLD_US) * 1000 / longint'(C_CLK_PRD_NS);
    localparam longint N_LOW      = (N_LOW_RAW < 1) ? 1 : N_LOW_RAW;
    localparam longint N_HIGH     = (N_HIGH_RAW < 1) ? 1 : N_HIGH_RAW;
    localparam longint N_MAX      = (N_LOW > N_HIGH) ? N_LOW : N_HIGH;
    localparam longint L          = longint'(C_LONG_PRESS_US) * 1000 / longint'(C_CLK_PRD_NS);
    localparam bit     LONG_EN    = (L > 0);
    // keeps the hold counter at least one bit wide when long-press is disabled
    localparam longint L_SAT      = LONG_EN ? L : 1;
    localparam int     CNT_W      = $clog2(N_MAX + 1);
    localparam int     HOLD_W     = $clog2(L_SAT + 1);

    localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(N_LOW - 1);
    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(N_HIGH - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(L_SAT - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(L_SAT);
    localparam logic              ACT       = C_KEY_ACTIVE;
    localparam logic              INACT     = ~C_KEY_ACTIVE;

    logic [C_CHANNELS-1:0] sync1, sync2, state, state_nxt;
    logic [C_CHANNELS-1:0] press_q, release_q, long_q;
    logic [C_CHANNELS-1:0] press_nxt, release_nxt, long_nxt;
    logic [CNT_W-1:0]      cnt      [C_CHANNELS];
    logic [CNT_W-1:0]      cnt_nxt  [C_CHANNELS];
    logic [HOLD_W-1:0]     hold     [C_CHANNELS];
    logic [HOLD_W-1:0]     hold_nxt [C_CHANNELS];

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            sync1     <= {C_CHANNELS{INACT}};
            sync2     <= {C_CHANNELS{INACT}};
            state     <= {C_CHANNELS{INACT}};
            press_q   <= '0;
            release_q <= '0;
            long_q    <= '0;
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                cnt[i]  <= '0;
                hold[i] <= '0;
            end
        end else begin
            sync1     <= KEY_I;
            sync2     <= sync1;
            state     <= state_nxt;
            press_q   <= press_nxt;
            release_q <= release_nxt;
            long_q    <= long_nxt;
            for (int unsigned i = 0; i < C_CHANNELS; i++) begin
                cnt[i]  <= cnt_nxt[i];
                hold[i] <= hold_nxt[i];
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        press_nxt   = '0;
        release_nxt = '0;
        long_nxt    = '0;
        for (int unsigned i = 0; i < C_CHANNELS; i++) begin
            cnt_nxt[i]  = '0;
            hold_nxt[i] = '0;
            if (sync2[i] != state[i]) begin
                if (cnt[i] == (sync2[i] ? HIGH_LAST : LOW_LAST))
                    state_nxt[i] = sync2[i];
                else
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
            end
            press_nxt[i]   = (state_nxt[i] == ACT) && (state[i] != ACT);
            release_nxt[i] = (state_nxt[i] != ACT) && (state[i] == ACT);
            // a release landing on the same edge as the hold limit suppresses the pulse
            if (state[i] == ACT) begin
                hold_nxt[i] = (hold[i] == HOLD_MAX) ? hold[i] : hold[i] + HOLD_W'(1);
                long_nxt[i] = LONG_EN && (hold[i] == HOLD_LAST) && (state_nxt[i] == ACT);
            end
        end
    end

    assign KEY_O     = state;
    assign PRESS_O   = press_q;
    assign RELEASE_O = release_q;
    assign LONG_O    = long_q;

endmodule
